// File: rtl/irq_pkg.sv
// rtl/irq_pkg.sv - shared constants, state encoding and priority helper for the interrupt gateway
package irq_pkg;

    localparam int IRQ_NUM_SRC = 6;
    localparam int IRQ_ID_W    = 3;

    localparam logic [IRQ_NUM_SRC-1:0] IRQ_EDGE_MASK_DEFAULT = 6'b000000;

    typedef enum logic {
        IRQ_IDLE    = 1'b0,
        IRQ_SERVICE = 1'b1
    } irq_state_e;

    // Fixed priority, index 0 wins; an empty vector reports 0.
    function automatic logic [IRQ_ID_W-1:0] irq_lowest_id(input logic [IRQ_NUM_SRC-1:0] req);
        logic [IRQ_ID_W-1:0] id;
        id = '0;
        for (int i = IRQ_NUM_SRC - 1; i >= 0; i--) begin
            if (req[i]) begin
                id = IRQ_ID_W'(i);
            end
        end
        return id;
    endfunction

endpackage

// File: rtl/irq_sync_edge.sv
// rtl/irq_sync_edge.sv - single-source two-flop synchroniser with edge/level gateway
module irq_sync_edge #(
    parameter bit IS_EDGE = 1'b0
) (
    input  logic clk_i,
    input  logic resetn_i,
    input  logic irq_i,
    input  logic pending_i,
    output logic set_req,
    output logic overrun_set
);

    logic s1_q;
    logic s2_q;
    logic s3_q;

    always_ff @(posedge clk_i) begin
        if (!resetn_i) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= irq_i;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    // s3 only exists to spot the rising edge of the synchronised level
    assign set_req     = IS_EDGE ? (s2_q & ~s3_q) : s2_q;
    assign overrun_set = IS_EDGE ? (s2_q & ~s3_q & pending_i) : 1'b0;

endmodule

// File: rtl/irq_pending_unit.sv
// rtl/irq_pending_unit.sv - pending/overrun registers, priority encoder and claim/complete FSM
module irq_pending_unit
    import irq_pkg::*;
#(
    parameter logic [IRQ_NUM_SRC-1:0] EDGE_MASK = IRQ_EDGE_MASK_DEFAULT,
    parameter int                     NUM_SRC   = IRQ_NUM_SRC
) (
    input  logic                Clock,
    input  logic                nReset,
    input  logic [NUM_SRC-1:0]  Irq_in,
    input  logic [NUM_SRC-1:0]  Enable_in,
    input  logic                Claim,
    input  logic                Complete,
    output logic [NUM_SRC-1:0]  Req_out,
    output logic                Irq_valid,
    output logic [IRQ_ID_W-1:0] Irq_id,
    output logic [IRQ_ID_W-1:0] Active_id,
    output logic [NUM_SRC-1:0]  Overrun
);

    irq_state_e          state_q;
    logic [IRQ_ID_W-1:0] active_q;
    logic [NUM_SRC-1:0]  pending_q, pending_d;
    logic [NUM_SRC-1:0]  overrun_q, overrun_d;
    logic [NUM_SRC-1:0]  set_req, ovr_set, clr;
    logic                claim_fire;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        irq_sync_edge #(
            .IS_EDGE (EDGE_MASK[i])
        ) u_sync (
            .clk_i       (Clock),
            .resetn_i    (nReset),
            .irq_i       (Irq_in[i]),
            .pending_i   (pending_q[i]),
            .set_req     (set_req[i]),
            .overrun_set (ovr_set[i])
        );
    end

    assign Req_out    = pending_q & Enable_in;
    assign Irq_id     = irq_lowest_id(Req_out);
    assign Irq_valid  = (state_q == IRQ_IDLE) && (|Req_out);
    assign claim_fire = Claim && Irq_valid;
    assign Active_id  = active_q;
    assign Overrun    = overrun_q;

    // An edge set beats a same-cycle claim so the event is kept; a level set does not.
    always_comb begin
        clr = '0;
        if (claim_fire) begin
            clr[Irq_id] = 1'b1;
        end
        pending_d = (set_req & (EDGE_MASK | ~clr)) | (pending_q & ~clr);
        overrun_d = (ovr_set & ~clr) | (overrun_q & ~clr);
    end

    always_ff @(posedge Clock) begin
        if (!nReset) begin
            state_q   <= IRQ_IDLE;
            active_q  <= '0;
            pending_q <= '0;
            overrun_q <= '0;
        end else begin
            pending_q <= pending_d;
            overrun_q <= overrun_d;
            case (state_q)
                IRQ_IDLE: begin
                    if (claim_fire) begin
                        state_q  <= IRQ_SERVICE;
                        active_q <= Irq_id;
                    end
                end
                IRQ_SERVICE: begin
                    if (Complete) begin
                        state_q <= IRQ_IDLE;
                    end
                end
                default: state_q <= IRQ_IDLE;
            endcase
        end
    end

endmodule
